ram_capture_ctrl: RTL and testbench

RAM_CAPTURE_CTRL -- requirements
Module: ram_capture_ctrl

---
 rtl/ram_capture_pkg.sv | 19 +
 rtl/ram_capture_apb_if.sv | 89 ++++++++
 rtl/ram_capture_ctrl.sv | 130 +++++++++++++
 tb/tb_ram_capture_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_capture_pkg.sv
// Shared definitions for the RAM capture controller: FSM states, APB register map
// and STATUS field layout.
package ram_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FULL    = 2'd2,
        ST_READ    = 2'd3
    } cap_state_e;

    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;

    localparam int unsigned STATUS_COUNT_LSB = 0;
    localparam int unsigned STATUS_COUNT_W   = 16;
    localparam int unsigned STATUS_STATE_LSB = 16;

endpackage

// File: rtl/ram_capture_apb_if.sv
// APB slave front end for the capture buffer: register decode, wait-state and error
// generation. Read parity checking is enabled by RAM_PARITY_EN.
module ram_capture_apb_if
    import ram_capture_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 9
) (
    input  logic          clk,
    input  logic          rst_h,
    input  logic          psel,
    input  logic          penable,
    input  logic          pwrite,
    input  logic [15:0]   paddr,
    input  cap_state_e    state,
    input  logic [CW-1:0] count,
    input  logic [DW:0]   ram_rdata,
    output logic          rd_issue,
    output logic          pop,
    output logic [31:0]   prdata,
    output logic          pready,
    output logic          pslverr
);

    logic        rd_wait_q, rd_wait_d;
    logic        pready_q, pready_d;
    logic        pslverr_q, pslverr_d;
    logic [31:0] prdata_q, prdata_d;
    logic        setup, can_pop, data_ok, status_rd, par_err;
    logic [31:0] status_word;
    logic        unused_bits;

`ifdef RAM_PARITY_EN
    assign par_err     = ^ram_rdata;
    assign unused_bits = ^paddr[15:4];
`else
    assign par_err     = 1'b0;
    assign unused_bits = ^{paddr[15:4], ram_rdata[DW]};
`endif

    always_comb begin
        setup     = psel && !penable;
        can_pop   = (state == ST_FULL || state == ST_READ) && count != '0;
        data_ok   = setup && !pwrite && paddr[3:0] == REG_DATA && can_pop;
        status_rd = setup && !pwrite && paddr[3:0] == REG_STATUS;

        status_word = '0;
        status_word[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(count);
        status_word[STATUS_STATE_LSB +: 2] = state;

        rd_wait_d = data_ok;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        // RAM data for an accepted DATA read lands during the first access cycle
        if (rd_wait_q) begin
            pready_d  = 1'b1;
            pslverr_d = par_err;
            prdata_d  = 32'(ram_rdata[DW-1:0]);
        end else if (status_rd) begin
            pready_d = 1'b1;
            prdata_d = status_word;
        end else if (setup && !data_ok) begin
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_h) begin
            rd_wait_q <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            rd_wait_q <= rd_wait_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    assign rd_issue = data_ok && !rst_h;
    assign pop      = rd_wait_q;
    assign prdata   = prdata_q;
    assign pready   = pready_q;
    assign pslverr  = pslverr_q;

endmodule

// File: rtl/ram_capture_ctrl.sv
// Capture controller: fills an external RAM from a sample generator, then drains it
// over APB one sample per DATA read. RAM_PARITY_EN adds a parity bit to each word.
module ram_capture_ctrl
    import ram_capture_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned DW    = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_h,
    input  logic          start,
    input  logic [DW-1:0] gen_data,
    input  logic          gen_valid,
    output logic [AW-1:0] ram_waddr,
    output logic [DW:0]   ram_wdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_raddr,
    output logic          ram_re,
    input  logic [DW:0]   ram_rdata,
    input  logic          psel,
    input  logic          penable,
    input  logic          pwrite,
    input  logic [15:0]   paddr,
    output logic [31:0]   prdata,
    output logic          pready,
    output logic          pslverr,
    output logic          full
);

    localparam int unsigned CW = AW + 1;

    cap_state_e    state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_en, rd_issue, pop, wpar;

`ifdef RAM_PARITY_EN
    assign wpar = ^gen_data;
`else
    assign wpar = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        // start low in CAPTURE closes the buffer, so a coincident sample is dropped
        wr_en   = state_q == ST_CAPTURE && start && gen_valid && !rst_h;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    wptr_d  = '0;
                    rptr_d  = '0;
                    count_d = '0;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (!start) begin
                    state_d = ST_FULL;
                end else if (gen_valid) begin
                    wptr_d  = wptr_q + 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_q == CW'(DEPTH - 1)) state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (rd_issue) begin
                    state_d = ST_READ;
                end else if (count_q == '0 && !psel) begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (pop) begin
                    rptr_d  = rptr_q + 1'b1;
                    count_d = count_q - 1'b1;
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_h) begin
            state_q <= ST_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    ram_capture_apb_if #(
        .DW(DW),
        .CW(CW)
    ) u_apb_if (
        .clk      (clk),
        .rst_h    (rst_h),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .state    (state_q),
        .count    (count_q),
        .ram_rdata(ram_rdata),
        .rd_issue (rd_issue),
        .pop      (pop),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    assign ram_we    = wr_en;
    assign ram_waddr = wptr_q;
    assign ram_wdata = wr_en ? {wpar, gen_data} : '0;
    assign ram_re    = rd_issue;
    assign ram_raddr = rptr_q;
    assign full      = (state_q == ST_FULL || state_q == ST_READ) && count_q == CW'(DEPTH);

endmodule

// File: tb/tb_ram_capture_ctrl.sv
// Directed self-checking bench for ram_capture_ctrl with a behavioural 1-cycle-read RAM.
module tb_ram_capture_ctrl;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned DW    = 8;
`ifdef RAM_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_h, start, gen_valid, psel, penable, pwrite;
    logic [7:0]  gen_data;
    logic [15:0] paddr;
    logic [7:0]  ram_waddr, ram_raddr;
    logic [8:0]  ram_wdata, ram_rdata;
    logic        ram_we, ram_re;
    logic [31:0] prdata;
    logic        pready, pslverr, full;

    logic [8:0]  mem [DEPTH];
    logic [8:0]  rdata_r = '0;
    logic        corrupt;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    ram_capture_ctrl #(
        .DEPTH(DEPTH),
        .DW   (DW)
    ) dut (
        .clk      (clk),
        .rst_h    (rst_h),
        .start    (start),
        .gen_data (gen_data),
        .gen_valid(gen_valid),
        .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata),
        .ram_we   (ram_we),
        .ram_raddr(ram_raddr),
        .ram_re   (ram_re),
        .ram_rdata(ram_rdata),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .full     (full)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (ram_re) rdata_r <= mem[ram_raddr];
    end
    assign ram_rdata = rdata_r ^ {corrupt, 8'h00};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apb_xfer(input logic wr, input logic [15:0] addr,
                            output logic [31:0] data, output logic err,
                            output int waits, output bit leak);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
        tick();
        penable = 1'b1;
        waits = 0;
        leak  = 1'b0;
        while (pready !== 1'b1 && waits < 6) begin
            if (prdata !== 32'h0 || pslverr !== 1'b0) leak = 1'b1;
            waits++;
            tick();
        end
        data = prdata;
        err  = pslverr;
        if (pready !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL apb_timeout addr=%h: pready still low after %0d cycles", addr, waits);
        end
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic capture(input logic [7:0] base, input int n);
        start = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            gen_valid = 1'b1;
            gen_data  = base + 8'(i);
            tick();
        end
        gen_valid = 1'b0;
        start     = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] d; logic e; int w; bit lk;
        rst_h = 1'b1;
        tick(); tick();
        n_tests++;
        if ({ram_we, ram_re, pready, pslverr, full} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000", {ram_we, ram_re, pready, pslverr, full});
        end
        n_tests++;
        if (prdata !== 32'h0 || ram_wdata !== 9'h0) begin
            n_fail++;
            $display("FAIL reset_data: prdata=%h wdata=%h expected 0", prdata, ram_wdata);
        end
        n_tests++;
        if (ram_waddr !== 8'h0 || ram_raddr !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_addr: waddr=%h raddr=%h expected 0", ram_waddr, ram_raddr);
        end
        rst_h = 1'b0;
        tick();
        apb_xfer(1'b0, 16'h4, d, e, w, lk);
        n_tests++;
        if (d !== 32'h0 || e !== 1'b0 || w != 0) begin
            n_fail++;
            $display("FAIL reset_status: got %h err=%b waits=%0d expected 0 0 0", d, e, w);
        end
    endtask

    task automatic test_full_capture();
        logic [31:0] d; logic e; int w; bit lk;
        start = 1'b1;
        tick();
        for (int i = 0; i < 256; i++) begin
            gen_valid = 1'b1;
            gen_data  = 8'(i);
            if (i == 7) begin
                #1;
                n_tests++;
                if (ram_we !== 1'b1 || ram_waddr !== 8'd7 || ram_wdata !== {PAR_ON, 8'h07}) begin
                    n_fail++;
                    $display("FAIL write_port: we=%b addr=%h data=%h expected 1 07 %h",
                             ram_we, ram_waddr, ram_wdata, {PAR_ON, 8'h07});
                end
            end
            tick();
        end
        gen_valid = 1'b0;
        start     = 1'b0;
        n_tests++;
        if (full !== 1'b1 || ram_waddr !== 8'h0) begin
            n_fail++;
            $display("FAIL full_wrap: full=%b waddr=%h expected 1 00", full, ram_waddr);
        end
        apb_xfer(1'b0, 16'h4, d, e, w, lk);
        n_tests++;
        if (d !== 32'h0002_0100 || e !== 1'b0 || w != 0) begin
            n_fail++;
            $display("FAIL status_full: got %h err=%b waits=%0d expected 00020100 0 0", d, e, w);
        end
        gen_valid = 1'b1;
        gen_data  = 8'hEE;
        #1;
        n_tests++;
        if (ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_valid: ram_we=%b expected 0", ram_we);
        end
        tick();
        gen_valid = 1'b0;
        apb_xfer(1'b0, 16'h4, d, e, w, lk);
        n_tests++;
        if (d !== 32'h0002_0100) begin
            n_fail++;
            $display("FAIL status_after_drop: got %h expected 00020100", d);
        end
    endtask

    task automatic test_drain_full();
        logic [31:0] d; logic e; int w; bit lk;
        for (int i = 0; i < 256; i++) begin
            apb_xfer(1'b0, 16'h0, d, e, w, lk);
            n_tests++;
            if (d !== 32'(i) || e !== 1'b0 || w != 1 || lk) begin
                n_fail++;
                $display("FAIL drain_%0d: data=%h err=%b waits=%0d leak=%b expected %h 0 1 0",
                         i, d, e, w, lk, 32'(i));
            end
        end
        tick(); tick();
        apb_xfer(1'b0, 16'h4, d, e, w, lk);
        n_tests++;
        if (d !== 32'h0 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_idle: status=%h full=%b expected 00000000 0", d, full);
        end
    endtask

    task automatic test_partial();
        logic [31:0] d; logic e; int w; bit lk;
        capture(8'h30, 10);
        apb_xfer(1'b0, 16'h4, d, e, w, lk);
        n_tests++;
        if (d !== 32'h0002_000A || full !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_status: got %h full=%b expected 0002000a 0", d, full);
        end
    endtask

    task automatic test_bad_access();
        logic [31:0] d; logic e; int w; bit lk;
        apb_xfer(1'b1, 16'h0, d, e, w, lk);
        n_tests++;
        if (d !== 32'h0 || e !== 1'b1 || w != 0) begin
            n_fail++;
            $display("FAIL write_err: data=%h err=%b waits=%0d expected 0 1 0", d, e, w);
        end
        apb_xfer(1'b0, 16'h8, d, e, w, lk);
        n_tests++;
        if (d !== 32'h0 || e !== 1'b1 || w != 0) begin
            n_fail++;
            $display("FAIL undecoded_err: data=%h err=%b waits=%0d expected 0 1 0", d, e, w);
        end
        apb_xfer(1'b0, 16'h4, d, e, w, lk);
        n_tests++;
        if (d !== 32'h0002_000A) begin
            n_fail++;
            $display("FAIL err_no_side_effect: status=%h expected 0002000a", d);
        end
    endtask

    task automatic test_partial_drain();
        logic [31:0] d; logic e; int w; bit lk;
        for (int i = 0; i < 10; i++) begin
            apb_xfer(1'b0, 16'h0, d, e, w, lk);
            n_tests++;
            if (d !== 32'h30 + 32'(i) || e !== 1'b0 || w != 1) begin
                n_fail++;
                $display("FAIL partial_read_%0d: data=%h err=%b waits=%0d expected %h 0 1",
                         i, d, e, w, 32'h30 + 32'(i));
            end
        end
        apb_xfer(1'b0, 16'h0, d, e, w, lk);
        n_tests++;
        if (d !== 32'h0 || e !== 1'b1 || w != 0) begin
            n_fail++;
            $display("FAIL empty_read: data=%h err=%b waits=%0d expected 0 1 0", d, e, w);
        end
        tick(); tick();
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] d; logic e; int w; bit lk;
        capture(8'hC0, 4);
        apb_xfer(1'b0, 16'h0, d, e, w, lk);
        n_tests++;
        if (d !== 32'hC0) begin
            n_fail++;
            $display("FAIL pre_reset_read: data=%h expected c0", d);
        end
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0;
        #1;
        n_tests++;
        if (ram_re !== 1'b1 || ram_raddr !== 8'd1) begin
            n_fail++;
            $display("FAIL read_issue: re=%b raddr=%h expected 1 01", ram_re, ram_raddr);
        end
        tick();
        penable = 1'b1;
        rst_h   = 1'b1;
        tick();
        n_tests++;
        if ({ram_we, ram_re, pready, pslverr, full} !== 5'b0 || prdata !== 32'h0) begin
            n_fail++;
            $display("FAIL midread_reset_ctrl: ctrl=%b prdata=%h expected 00000 0",
                     {ram_we, ram_re, pready, pslverr, full}, prdata);
        end
        n_tests++;
        if (ram_waddr !== 8'h0 || ram_raddr !== 8'h0 || ram_wdata !== 9'h0) begin
            n_fail++;
            $display("FAIL midread_reset_addr: waddr=%h raddr=%h wdata=%h expected 0",
                     ram_waddr, ram_raddr, ram_wdata);
        end
        rst_h = 1'b0; psel = 1'b0; penable = 1'b0;
        tick();
        apb_xfer(1'b0, 16'h4, d, e, w, lk);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL midread_reset_status: got %h expected 0", d);
        end
        capture(8'h5A, 3);
        apb_xfer(1'b0, 16'h4, d, e, w, lk);
        n_tests++;
        if (d !== 32'h0002_0003) begin
            n_fail++;
            $display("FAIL recapture_status: got %h expected 00020003", d);
        end
        for (int i = 0; i < 3; i++) begin
            apb_xfer(1'b0, 16'h0, d, e, w, lk);
            n_tests++;
            if (d !== 32'h5A + 32'(i) || e !== 1'b0 || w != 1) begin
                n_fail++;
                $display("FAIL recapture_read_%0d: data=%h err=%b waits=%0d expected %h 0 1",
                         i, d, e, w, 32'h5A + 32'(i));
            end
        end
        tick(); tick();
    endtask

    task automatic test_parity();
        logic [31:0] d; logic e; int w; bit lk;
        logic exp_err;
        capture(8'h60, 8);
        for (int i = 0; i < 8; i++) begin
            corrupt = (i == 5);
            apb_xfer(1'b0, 16'h0, d, e, w, lk);
            corrupt = 1'b0;
            exp_err = PAR_ON && (i == 5);
            n_tests++;
            if (e !== exp_err || w != 1 || (d !== 32'h60 + 32'(i) && !exp_err)) begin
                n_fail++;
                $display("FAIL parity_read_%0d: data=%h err=%b waits=%0d expected %h %b 1",
                         i, d, e, w, 32'h60 + 32'(i), exp_err);
            end
            if (i == 5) begin
                apb_xfer(1'b0, 16'h4, d, e, w, lk);
                n_tests++;
                if (d !== 32'h0002_0002) begin
                    n_fail++;
                    $display("FAIL parity_consume: status=%h expected 00020002", d);
                end
            end
        end
        tick(); tick();
    endtask

    initial begin
        rst_h = 1'b0; start = 1'b0; gen_valid = 1'b0; gen_data = 8'h0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0; corrupt = 1'b0;
        test_reset();
        test_full_capture();
        test_drain_full();
        test_partial();
        test_bad_access();
        test_partial_drain();
        test_reset_mid_read();
        test_parity();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
